// File: rtl/d_memory_bank_pkg.sv
// Shared definitions for the data memory bank: FSM encoding, lane sizing and
// read-latency parameter handling.
package d_memory_bank_pkg;

  localparam int unsigned STATE_W = 1;
  localparam logic [STATE_W-1:0] ST_INIT = 1'b0;
  localparam logic [STATE_W-1:0] ST_RUN  = 1'b1;

  localparam int unsigned BYTE_W = 8;

  // Only latencies of 1 and 2 exist in hardware; anything else collapses to 1.
  function automatic int unsigned eff_read_lat(input int unsigned lat);
    return (lat == 32'd2) ? 32'd2 : 32'd1;
  endfunction

  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Single-port word array with per-byte write enables and a registered read port.
module dmem_byte_ram
  import d_memory_bank_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       re,
  input  logic [LANES-1:0]           we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [LANES*BYTE_W-1:0]    wdata,
  output logic [LANES*BYTE_W-1:0]    rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [LANES-1:0][BYTE_W-1:0] mem [DEPTH];

  // Storage array carries no reset; the owner zero-fills it after reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (we[i]) begin
        mem[addr][i] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read register only updates on an accepted read so the value is held between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/d_memory_bank.sv
// Data memory bank: zero-fill sequencer, byte-enable writes and a 1- or 2-cycle
// registered read pipeline behind a req/ready/rvalid handshake.
module d_memory_bank
  import d_memory_bank_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W/8-1:0]  be,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 clr,
  output logic                 ready,
  output logic                 rvalid,
  output logic [DATA_W-1:0]    rdata,
  output logic                 init_busy
);

  localparam int unsigned LANES = lane_count(DATA_W);
  localparam bit          LAT2  = (eff_read_lat(READ_LAT) == 32'd2);

  logic [STATE_W-1:0] state, state_nxt;
  logic [ADDR_W-1:0]  init_cnt, init_cnt_nxt;
  logic               init_busy_nxt;

  logic               accept;
  logic               rd_accept;
  logic [LANES-1:0]   ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_q;
  logic               rd_v1;

  // clr takes priority over any request arriving in the same cycle.
  assign ready     = (state == ST_RUN) && !clr;
  assign accept    = req && ready;
  assign rd_accept = accept && !we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_busy <= 1'b1;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      init_busy <= init_busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      ST_INIT: begin
        init_cnt_nxt = init_cnt + ADDR_W'(1);
        if (init_cnt == '1) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_nxt    = ST_INIT;
          init_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = ST_INIT;
        init_cnt_nxt = '0;
      end
    endcase
    init_busy_nxt = (state_nxt == ST_INIT);
  end

  // Write port mux: the zero-fill owns the array during INIT.
  always_comb begin
    ram_we    = '0;
    ram_addr  = addr;
    ram_wdata = wdata;
    if (state == ST_INIT) begin
      ram_we    = '1;
      ram_addr  = init_cnt;
      ram_wdata = '0;
    end else if (accept && we) begin
      ram_we = be;
    end
  end

  dmem_byte_ram #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .re    (rd_accept),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v1 <= 1'b0;
    end else begin
      rd_v1 <= rd_accept;
    end
  end

  if (LAT2) begin : g_lat2
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    // Second stage captures only on a valid first stage so rdata holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rd_v1;
        if (rd_v1) begin
          rdata_q <= ram_q;
        end
      end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
  end else begin : g_lat1
    assign rvalid = rd_v1;
    assign rdata  = ram_q;
  end

endmodule

// File: tb/tb_d_memory_bank.sv
// Directed bench for d_memory_bank: two instances (READ_LAT 1 and 2) share stimulus
// and are compared every cycle against a transaction-level model of the memory.
module tb_d_memory_bank;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, clr;
  logic [7:0]  addr;
  logic [1:0]  be;
  logic [15:0] wdata;

  logic        ready1, rvalid1, init_busy1;
  logic [15:0] rdata1;
  logic        ready2, rvalid2, init_busy2;
  logic [15:0] rdata2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_memory_bank #(.DATA_W(16), .ADDR_W(8), .READ_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
    .clr(clr), .ready(ready1), .rvalid(rvalid1), .rdata(rdata1), .init_busy(init_busy1)
  );

  d_memory_bank #(.DATA_W(16), .ADDR_W(8), .READ_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
    .clr(clr), .ready(ready2), .rvalid(rvalid2), .rdata(rdata2), .init_busy(init_busy2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: memory image, init progress and per-latency delivery queues.
  typedef struct { int due; logic [15:0] d; } rd_t;
  logic [15:0] mm [DEPTH];
  bit          m_run;
  int          m_left;
  int          cyc;
  rd_t         q1[$], q2[$];
  bit          m_v1, m_v2;
  logic [15:0] m_rd1, m_rd2;

  task automatic model_reset();
    m_run = 1'b0; m_left = DEPTH; q1.delete(); q2.delete();
    m_v1 = 1'b0; m_v2 = 1'b0; m_rd1 = '0; m_rd2 = '0;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        cyc++;
        if (!m_run) begin
          mm[DEPTH - m_left] = '0;
          m_left--;
          if (m_left == 0) m_run = 1'b1;
        end else if (clr) begin
          m_run  = 1'b0;
          m_left = DEPTH;
        end else if (req) begin
          if (we) begin
            if (be[0]) mm[addr][7:0]  = wdata[7:0];
            if (be[1]) mm[addr][15:8] = wdata[15:8];
          end else begin
            q1.push_back('{cyc,     mm[addr]});
            q2.push_back('{cyc + 1, mm[addr]});
          end
        end
        m_v1 = (q1.size() > 0) && (q1[0].due == cyc);
        if (m_v1) begin m_rd1 = q1[0].d; void'(q1.pop_front()); end
        m_v2 = (q2.size() > 0) && (q2[0].due == cyc);
        if (m_v2) begin m_rd2 = q2[0].d; void'(q2.pop_front()); end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("L1 ready",     ready1,     m_run && !clr);
      chk("L1 init_busy", init_busy1, !m_run);
      chk("L1 rvalid",    rvalid1,    m_v1);
      chk("L1 rdata",     rdata1,     m_rd1);
      chk("L2 ready",     ready2,     m_run && !clr);
      chk("L2 init_busy", init_busy2, !m_run);
      chk("L2 rvalid",    rvalid2,    m_v2);
      chk("L2 rdata",     rdata2,     m_rd2);
    end
  end

  task automatic drive(input logic r, input logic w, input logic [7:0] a,
                       input logic [1:0] b, input logic [15:0] d, input logic c);
    @(negedge clk);
    req = r; we = w; addr = a; be = b; wdata = d; clr = c;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 2'b00, 16'h0000, 1'b0);
  endtask

  task automatic read_chk(input logic [7:0] a, input logic [15:0] exp, input string nm);
    drive(1'b1, 1'b0, a, 2'b11, 16'h0000, 1'b0);
    @(posedge clk); #1;
    chk({nm, " lat1 rvalid"}, rvalid1, 1'b1);
    chk({nm, " lat1 rdata"},  rdata1,  exp);
    chk({nm, " lat2 early"},  rvalid2, 1'b0);
    idle();
    @(posedge clk); #1;
    chk({nm, " lat2 rvalid"}, rvalid2, 1'b1);
    chk({nm, " lat2 rdata"},  rdata2,  exp);
    chk({nm, " lat1 drop"},   rvalid1, 1'b0);
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (init_busy1 && n < 400);
    chk({nm, " init cycles"}, n, 256);
    chk({nm, " ready after init"}, ready1, 1'b1);
  endtask

  task automatic rst_values(input string nm);
    chk({nm, " ready"},     {ready1, ready2},         2'b00);
    chk({nm, " rvalid"},    {rvalid1, rvalid2},       2'b00);
    chk({nm, " rdata1"},    rdata1,                   16'h0000);
    chk({nm, " rdata2"},    rdata2,                   16'h0000);
    chk({nm, " init_busy"}, {init_busy1, init_busy2}, 2'b11);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; clr = 1'b0;
    #12;
    rst_values("por");
    @(negedge clk);
    rst = 1'b0;
    wait_init("por");

    read_chk(8'h00, 16'h0000, "zero00");
    read_chk(8'h7F, 16'h0000, "zero7f");
    read_chk(8'hFF, 16'h0000, "zeroff");

    drive(1'b1, 1'b1, 8'h10, 2'b11, 16'hABCD, 1'b0);
    drive(1'b1, 1'b1, 8'h10, 2'b01, 16'h1234, 1'b0);
    read_chk(8'h10, 16'hAB34, "merge");

    drive(1'b1, 1'b1, 8'h01, 2'b11, 16'h3C00, 1'b0);
    read_chk(8'h01, 16'h3C00, "raw");
    drive(1'b1, 1'b1, 8'h01, 2'b00, 16'hFFFF, 1'b0);
    read_chk(8'h01, 16'h3C00, "be0");

    // Back-to-back reads deliver in order at full rate.
    drive(1'b1, 1'b0, 8'h00, 2'b00, 16'h0000, 1'b0);
    @(posedge clk); #1;
    chk("b2b first lat1", {rvalid1, rdata1}, {1'b1, 16'h0000});
    drive(1'b1, 1'b0, 8'h01, 2'b00, 16'h0000, 1'b0);
    @(posedge clk); #1;
    chk("b2b second lat1", {rvalid1, rdata1}, {1'b1, 16'h3C00});
    chk("b2b first lat2",  {rvalid2, rdata2}, {1'b1, 16'h0000});
    idle();
    @(posedge clk); #1;
    chk("b2b second lat2", {rvalid2, rdata2}, {1'b1, 16'h3C00});

    // Read one cycle ahead of clr, then clr together with a write request.
    drive(1'b1, 1'b0, 8'h01, 2'b00, 16'h0000, 1'b0);
    @(posedge clk); #1;
    chk("preclr lat1", {rvalid1, rdata1}, {1'b1, 16'h3C00});
    drive(1'b1, 1'b1, 8'h10, 2'b11, 16'hFFFF, 1'b1);
    #1;
    chk("clr blocks ready", {ready1, ready2}, 2'b00);
    @(posedge clk); #1;
    chk("preclr lat2", {rvalid2, rdata2}, {1'b1, 16'h3C00});
    chk("clr busy",    init_busy1, 1'b1);
    idle();
    wait_init("clr");
    read_chk(8'h10, 16'h0000, "clr10");
    read_chk(8'h01, 16'h0000, "clr01");

    drive(1'b1, 1'b1, 8'h05, 2'b11, 16'hBEEF, 1'b0);
    read_chk(8'h05, 16'hBEEF, "beef");

    // Reset with a read in flight.
    drive(1'b1, 1'b0, 8'h05, 2'b00, 16'h0000, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    rst_values("rst_rd");
    idle();
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of INIT at init_cnt=0x40.
    repeat (64) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    rst_values("rst_init");
    @(negedge clk);
    rst = 1'b0;
    wait_init("rst");
    read_chk(8'h05, 16'h0000, "rst05");

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
